ssd1306_fb_streamer: RTL and testbench
======================================

Name: ssd1306_fb_streamer

Overview:
- Upstream feeder for the I2C master in the SSD1306 OLED path.
- Reads a 128x64 monochrome framebuffer (1024 bytes, page-major) from a synchronous RAM.
- Sends it to the panel as fixed 3-byte I2C write transactions: one set of command transactions to set the address window, then data transactions.
- Sits between the framebuffer RAM and the i2c master's din/vin/busy interface. Panel init is handled elsewhere.

Parameters:
- COLS, 128, columns per page.
- PAGES, 8, pages per frame.
- ADDR_W, 10, framebuffer address width; must satisfy 2**ADDR_W >= COLS*PAGES.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  one-cycle pulse; begins a frame refresh when idle
- busy  out  1  high from start accept until frame_done
- frame_done  out  1  one-cycle pulse after the last data transaction completes
- fb_addr  out  ADDR_W  framebuffer read address
- fb_rd_en  out  1  framebuffer read strobe
- fb_rdata  in  8  read data, valid exactly 1 cycle after fb_rd_en
- txn_data  out  24  transaction bytes; [23:16] is sent first, [7:0] last
- txn_valid  out  1  one-cycle pulse to the master's vin
- txn_busy  in  1  master busy; rises the cycle after vin, falls at STOP

Behaviour:
- Reset values: busy=0, frame_done=0, fb_addr=0, fb_rd_en=0, txn_data=0, txn_valid=0, state=IDLE, all counters 0.
- Reset mid-frame returns to IDLE immediately. No further txn_valid is issued. An in-flight master transaction is not aborted.
- Command transactions are fixed and sent in order (k=0..3):
  - C0 = {00,20,00}: horizontal addressing mode.
  - C1 = {00,21,00}: column address command, start=0.
  - C2 = {00,7F,22}: column end, page address command.
  - C3 = {00,00,07}: page start 0, page end.
- Column end = COLS-1 and page end = PAGES-1; defaults are 7F and 07.
- Data transactions are {40, fb[2n], fb[2n+1]} for n = 0..(COLS*PAGES/2 - 1), i.e. 512 at defaults.
- States:
  - IDLE: wait for start.
  - CMD_LOAD: place Ck on txn_data.
  - FETCH_A: fb_addr=2n, fb_rd_en=1.
  - FETCH_B: fb_addr=2n+1, fb_rd_en=1; capture fb_rdata as byte A.
  - FETCH_C: fb_rd_en=0; capture fb_rdata as byte B; load txn_data.
  - ISSUE: pulse txn_valid when txn_busy=0.
  - WAIT_ACC: wait for txn_busy=1.
  - WAIT_DONE: wait for txn_busy=0.
  - DONE.
- Transitions:
  - IDLE + start → CMD_LOAD; set busy=1, k=0, n=0.
  - CMD_LOAD → ISSUE.
  - FETCH_A → FETCH_B → FETCH_C → ISSUE.
  - ISSUE → WAIT_ACC in the cycle txn_valid=1. txn_valid is never asserted while txn_busy=1; ISSUE holds until txn_busy=0.
  - WAIT_ACC → WAIT_DONE when txn_busy=1.
  - WAIT_DONE, when txn_busy=0:
    - command phase, k<3: k++, → CMD_LOAD.
    - command phase, k=3: → FETCH_A.
    - data phase, n < last: n++, → FETCH_A.
    - data phase, n = last: → DONE.
  - DONE: frame_done=1 for one cycle, busy=0, → IDLE.
- txn_data is stable from its load cycle until WAIT_DONE exits.
- start while busy=1 is ignored; there is no queueing.
- start coincident with rst: rst wins.
- Address arithmetic:
  - 2n+1 wraps modulo 2**ADDR_W; it never exceeds COLS*PAGES-1 at legal parameters.
  - n counter width is ADDR_W-1 bits.
- Latency from start to first txn_valid: 2 cycles (IDLE → CMD_LOAD → ISSUE with txn_busy=0).
- Gap between successive data txn_valid pulses: master transaction time + 4 cycles (WAIT_DONE exit, FETCH_A/B/C, ISSUE).

Test Plan:
- Order and contents: reset, start pulse, master model with busy=1 for 20 cycles per vin.
  - txn_data sequence: 002000, 002100, 007F22, 000007, then 40 fb[0] fb[1], …
  - Exactly 516 txn_valid pulses, then one frame_done; busy low after.
- Data integrity: fb[i] = i[7:0] ^ 8'hA5.
  - Data transaction n carries {40, (2n)^A5, (2n+1)^A5}.
  - Last transaction = {40, FE^A5, FF^A5} = {40,5B,5A}.
  - fb_addr never exceeds 0x3FF.
- Handshake: hold txn_busy=1 externally before start.
  - No txn_valid until txn_busy drops.
  - Then first txn_valid within 1 cycle with txn_data=002000.
  - No txn_valid while txn_busy=1 at any point.
- start during frame: pulse start at transaction 100.
  - Total pulses remain 516; a single frame_done.
- Reset mid-frame: assert rst during WAIT_DONE of data transaction 10.
  - Outputs return to reset values next cycle; no txn_valid afterwards.
  - A new start produces a full 516-transaction frame beginning with 002000.
- Back-to-back frames: start the same cycle frame_done is seen (busy=0 next cycle).
  - Second frame is accepted on that start; first txn_valid 2 cycles later.

Source files
------------

// File: rtl/ssd1306_fb_streamer_if.sv
// ssd1306_fb_streamer_if
// Groups the framebuffer read port, the I2C master handshake and the
// frame control strobes of the SSD1306 framebuffer streamer.
//   master modport : the streamer (drives busy, frame_done, fb_addr, fb_rd_en,
//                    txn_data, txn_valid; receives start, fb_rdata, txn_busy)
//   slave modport  : the surrounding system (RAM, I2C master, frame control)
interface ssd1306_fb_streamer_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              busy;
    logic              frame_done;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_rd_en;
    logic [7:0]        fb_rdata;
    logic [23:0]       txn_data;
    logic              txn_valid;
    logic              txn_busy;

    modport master (
        input  start, fb_rdata, txn_busy,
        output busy, frame_done, fb_addr, fb_rd_en, txn_data, txn_valid
    );

    modport slave (
        output start, fb_rdata, txn_busy,
        input  busy, frame_done, fb_addr, fb_rd_en, txn_data, txn_valid
    );
endinterface

// File: rtl/ssd1306_fb_streamer.sv
// ssd1306_fb_streamer
// Streams a page-major monochrome framebuffer to an SSD1306 panel as fixed
// 3-byte I2C write transactions: four command transactions that set
// horizontal addressing and the full address window, followed by one data
// transaction {0x40, fb[2n], fb[2n+1]} per byte pair.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : master side of ssd1306_fb_streamer_if
//              start/busy/frame_done  frame control
//              fb_addr/fb_rd_en/fb_rdata  synchronous RAM read (1-cycle latency)
//              txn_data/txn_valid/txn_busy  I2C master din/vin/busy
module ssd1306_fb_streamer #(
    parameter int COLS   = 128,
    parameter int PAGES  = 8,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    ssd1306_fb_streamer_if.master bus
);
    localparam int              NUM_TXN  = COLS * PAGES / 2;
    localparam logic [ADDR_W-2:0] N_LAST = (ADDR_W-1)'(NUM_TXN - 1);
    localparam logic [7:0]      COL_END  = 8'(COLS - 1);
    localparam logic [7:0]      PAGE_END = 8'(PAGES - 1);
    localparam logic [ADDR_W-2:0] N_ONE  = {{(ADDR_W-2){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        IDLE, CMD_LOAD, FETCH_A, FETCH_B, FETCH_C,
        ISSUE, WAIT_ACC, WAIT_DONE, DONE
    } state_t;

    state_t            state;
    logic [1:0]        k;
    logic [ADDR_W-2:0] n;
    logic [ADDR_W-2:0] n_next;
    logic              in_data;
    logic [7:0]        byte_a;

    logic              busy_r;
    logic              frame_done_r;
    logic [ADDR_W-1:0] fb_addr_r;
    logic              fb_rd_en_r;
    logic [23:0]       txn_data_r;
    logic              txn_valid_r;

    assign n_next         = n + N_ONE;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_r;
    assign bus.fb_addr    = fb_addr_r;
    assign bus.fb_rd_en   = fb_rd_en_r;
    assign bus.txn_data   = txn_data_r;
    assign bus.txn_valid  = txn_valid_r;

    // Address-window setup: horizontal mode, columns 0..COLS-1, pages 0..PAGES-1.
    function automatic logic [23:0] cmd_word(input logic [1:0] idx);
        case (idx)
            2'd0:    cmd_word = {8'h00, 8'h20, 8'h00};
            2'd1:    cmd_word = {8'h00, 8'h21, 8'h00};
            2'd2:    cmd_word = {8'h00, COL_END, 8'h22};
            default: cmd_word = {8'h00, 8'h00, PAGE_END};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            k            <= '0;
            n            <= '0;
            in_data      <= 1'b0;
            byte_a       <= '0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            fb_addr_r    <= '0;
            fb_rd_en_r   <= 1'b0;
            txn_data_r   <= '0;
            txn_valid_r  <= 1'b0;
        end else begin
            txn_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            case (state)
                // DONE behaves like IDLE for start so frames can run back to back;
                // busy is already low there.
                IDLE, DONE: begin
                    if (bus.start) begin
                        busy_r  <= 1'b1;
                        k       <= '0;
                        n       <= '0;
                        in_data <= 1'b0;
                        state   <= CMD_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                // txn_valid is registered, so it is raised on entry to ISSUE
                // when the master is already idle; otherwise ISSUE raises it.
                CMD_LOAD: begin
                    txn_data_r  <= cmd_word(k);
                    txn_valid_r <= !bus.txn_busy;
                    state       <= ISSUE;
                end
                // fb_addr/fb_rd_en are set one state early so the RAM sees
                // 2n during FETCH_A and 2n+1 during FETCH_B.
                FETCH_A: begin
                    fb_addr_r <= {n, 1'b1};
                    state     <= FETCH_B;
                end
                FETCH_B: begin
                    fb_rd_en_r <= 1'b0;
                    byte_a     <= bus.fb_rdata;
                    state      <= FETCH_C;
                end
                FETCH_C: begin
                    txn_data_r  <= {8'h40, byte_a, bus.fb_rdata};
                    txn_valid_r <= !bus.txn_busy;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    if (txn_valid_r) begin
                        state <= WAIT_ACC;
                    end else if (!bus.txn_busy) begin
                        txn_valid_r <= 1'b1;
                    end
                end
                WAIT_ACC: begin
                    if (bus.txn_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.txn_busy) begin
                        if (!in_data) begin
                            if (k == 2'd3) begin
                                in_data    <= 1'b1;
                                fb_addr_r  <= {n, 1'b0};
                                fb_rd_en_r <= 1'b1;
                                state      <= FETCH_A;
                            end else begin
                                k     <= k + 2'd1;
                                state <= CMD_LOAD;
                            end
                        end else if (n == N_LAST) begin
                            frame_done_r <= 1'b1;
                            busy_r       <= 1'b0;
                            state        <= DONE;
                        end else begin
                            n          <= n_next;
                            fb_addr_r  <= {n_next, 1'b0};
                            fb_rd_en_r <= 1'b1;
                            state      <= FETCH_A;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ssd1306_fb_streamer.sv
// tb_ssd1306_fb_streamer
// Directed bench for ssd1306_fb_streamer: framebuffer RAM model with
// fb[i] = i[7:0] ^ 8'hA5, an I2C master model that holds busy for 20 cycles
// after each vin, a monitor that scores every transaction against a reference
// sequence, and hand-written sequences for handshake, reset and restart cases.
module tb_ssd1306_fb_streamer;
    localparam int TOTAL_TXN = 516;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold_busy = 1'b0;
    logic mon_clr = 1'b0;
    int   mst_cnt = 0;

    ssd1306_fb_streamer_if #(.ADDR_W(10)) bus ();

    ssd1306_fb_streamer #(.COLS(128), .PAGES(8), .ADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // I2C master model: busy rises the cycle after vin, stays high 20 cycles.
    always @(posedge clk) begin
        if (mst_cnt != 0) mst_cnt <= mst_cnt - 1;
        else if (bus.txn_valid) mst_cnt <= 20;
    end
    assign bus.txn_busy = hold_busy | (mst_cnt != 0);

    // Synchronous framebuffer RAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.fb_rd_en) bus.fb_rdata <= bus.fb_addr[7:0] ^ 8'hA5;
    end

    function automatic logic [23:0] exp_txn(input int i);
        logic [9:0] a;
        logic [9:0] b;
        case (i)
            0: return 24'h002000;
            1: return 24'h002100;
            2: return 24'h007F22;
            3: return 24'h000007;
            default: begin
                a = 10'((i - 4) * 2);
                b = a + 10'd1;
                return {8'h40, a[7:0] ^ 8'hA5, b[7:0] ^ 8'hA5};
            end
        endcase
    endfunction

    int          pulse_cnt = 0;
    int          done_cnt  = 0;
    int          seq_err   = 0;
    int          viol_cnt  = 0;
    int          addr_err  = 0;
    int          exp_addr  = 0;
    logic [23:0] cap [0:1023];

    always @(negedge clk) begin
        if (mon_clr) begin
            pulse_cnt = 0;
            done_cnt  = 0;
            seq_err   = 0;
            viol_cnt  = 0;
            addr_err  = 0;
            exp_addr  = 0;
        end else if (!rst) begin
            if (bus.txn_valid) begin
                if (bus.txn_busy) viol_cnt++;
                if (bus.txn_data !== exp_txn(pulse_cnt)) seq_err++;
                if (pulse_cnt < 1024) cap[pulse_cnt] = bus.txn_data;
                pulse_cnt++;
            end
            if (bus.frame_done) done_cnt++;
            if (bus.fb_rd_en) begin
                if (bus.fb_addr !== exp_addr[9:0]) addr_err++;
                exp_addr++;
            end
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int limit);
        int i = 0;
        while (pulse_cnt != target && i < limit) begin
            tick();
            i++;
        end
        check("wait_pulses", pulse_cnt, target);
    endtask

    task automatic wait_done(input int limit);
        int i = 0;
        while (done_cnt == 0 && i < limit) begin
            tick();
            i++;
        end
        check("wait_frame_done", done_cnt, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       bus.busy, 0);
        check({tag, "_frame_done"}, bus.frame_done, 0);
        check({tag, "_fb_addr"},    bus.fb_addr, 0);
        check({tag, "_fb_rd_en"},   bus.fb_rd_en, 0);
        check({tag, "_txn_data"},   bus.txn_data, 0);
        check({tag, "_txn_valid"},  bus.txn_valid, 0);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_pulses"},     pulse_cnt, TOTAL_TXN);
        check({tag, "_seq_errors"}, seq_err, 0);
        check({tag, "_busy_viol"},  viol_cnt, 0);
        check({tag, "_addr_errs"},  addr_err, 0);
        check({tag, "_reads"},      exp_addr, 1024);
    endtask

    typedef struct {
        int          idx;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl [0:8];

    initial begin
        tbl[0] = '{0,   24'h002000};
        tbl[1] = '{1,   24'h002100};
        tbl[2] = '{2,   24'h007F22};
        tbl[3] = '{3,   24'h000007};
        tbl[4] = '{4,   24'h40A5A4};
        tbl[5] = '{5,   24'h40A7A6};
        tbl[6] = '{100, 24'h406564};
        tbl[7] = '{132, 24'h40A5A4};
        tbl[8] = '{515, 24'h405B5A};

        bus.start = 1'b0;
        rst = 1'b1;
        mon_clr = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        mon_clr = 1'b0;
        tick();
        check_reset_outputs("reset");

        // start coincident with reset is dropped
        rst = 1'b1;
        bus.start = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (4) tick();
        check("start_with_rst_busy", bus.busy, 0);
        check("start_with_rst_pulses", pulse_cnt, 0);

        // Frame 1: master held busy before start, extra start mid-frame
        hold_busy = 1'b1;
        pulse_start();
        repeat (10) tick();
        check("held_busy_no_valid", pulse_cnt, 0);
        check("held_busy_streamer_busy", bus.busy, 1);
        hold_busy = 1'b0;
        tick();
        check("release_valid", bus.txn_valid, 1);
        check("release_data", bus.txn_data, 24'h002000);
        wait_pulses(100, 5000);
        pulse_start();
        wait_done(20000);
        repeat (30) tick();
        check_frame("frame1");
        check("frame1_done_count", done_cnt, 1);
        check("frame1_busy_after", bus.busy, 0);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("txn_%0d", tbl[i].idx), cap[tbl[i].idx], tbl[i].exp);
        end

        // Frame 2: reset while waiting on data transaction 10
        clear_mon();
        pulse_start();
        wait_pulses(15, 2000);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("midreset");
        rst = 1'b0;
        repeat (40) tick();
        check("midreset_no_more_valid", pulse_cnt, 15);
        check("midreset_idle", bus.busy, 0);

        // Frame 3 after reset, then frame 4 started on frame_done
        clear_mon();
        pulse_start();
        wait_done(20000);
        check("frame3_done_pulse", bus.frame_done, 1);
        check("frame3_busy_low", bus.busy, 0);
        check_frame("frame3");
        check("frame3_first", cap[0], 24'h002000);
        bus.start = 1'b1;
        mon_clr = 1'b1;
        tick();
        bus.start = 1'b0;
        mon_clr = 1'b0;
        check("b2b_accept_busy", bus.busy, 1);
        check("b2b_valid_1cyc", bus.txn_valid, 0);
        tick();
        check("b2b_valid_2cyc", bus.txn_valid, 1);
        check("b2b_data", bus.txn_data, 24'h002000);
        wait_done(20000);
        repeat (30) tick();
        check_frame("frame4");
        check("frame4_done_count", done_cnt, 1);
        check("frame4_busy_after", bus.busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
